// File: rtl/wb_pkg.sv
// wb_pkg: shared state encoding and default widths for the write-back commit buffer
package wb_pkg;

    typedef enum logic [1:0] {IDLE, REQ, REL} wb_state_t;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 4;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular write buffer with occupancy count and youngest-match forwarding search
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [ADDR_W-1:0]          push_addr,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    input  logic [ADDR_W-1:0]          fwd_addr,
    output logic [ADDR_W-1:0]          head_addr,
    output logic [DATA_W-1:0]          head_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       fwd_hit,
    output logic [DATA_W-1:0]          fwd_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    // pointers wrap on their own because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // storage is unreset: an entry is only visible while it is counted
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    assign full      = count == CNT_W'(DEPTH);
    assign head_addr = (count != '0) ? addr_mem[rd_ptr] : '0;
    assign head_data = (count != '0) ? data_mem[rd_ptr] : '0;

    // walk oldest to youngest so the last match kept is the youngest
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count && addr_mem[rd_ptr + PTR_W'(i)] == fwd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem[rd_ptr + PTR_W'(i)];
            end
        end
    end

endmodule

// File: rtl/wb_commit.sv
// wb_commit: buffers ALU results and commits them to the register file over a 4-phase handshake
module wb_commit
    import wb_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_result,
    input  logic [ADDR_W-1:0]          in_rd,
    input  logic                       in_we,
    output logic                       rf_req,
    input  logic                       rf_ack,
    output logic                       rf_we,
    output logic [ADDR_W-1:0]          rf_addr,
    output logic [DATA_W-1:0]          rf_data,
    input  logic [ADDR_W-1:0]          fwd_addr,
    output logic                       fwd_hit,
    output logic [DATA_W-1:0]          fwd_data,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic                       err_timeout
);

    localparam int TW = $clog2(TIMEOUT + 1);

    wb_state_t     state;
    wb_state_t     state_nxt;
    logic [TW-1:0] wait_cnt;
    logic [TW-1:0] wait_nxt;
    logic          err_nxt;
    logic          full;
    logic          push;
    logic          pop;
    logic          timed_out;

    assign in_ready  = !full;
    assign push      = in_valid && in_ready && in_we;
    assign rf_req    = state == REQ;
    assign rf_we     = rf_req;
    assign timed_out = !rf_ack && wait_cnt == TW'(TIMEOUT - 1);

    wb_fifo #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_addr(in_rd),
        .push_data(in_result),
        .pop      (pop),
        .fwd_addr (fwd_addr),
        .head_addr(rf_addr),
        .head_data(rf_data),
        .count    (pending),
        .full     (full),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data)
    );

    // handshake state, ack wait counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_nxt;
            err_timeout <= err_nxt;
        end
    end

    // four-phase sequencing; the head is popped only once the file releases ack
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        err_nxt   = err_timeout;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                wait_nxt = '0;
                if (pending != '0) state_nxt = REQ;
            end
            REQ: begin
                wait_nxt = rf_ack ? wait_cnt : wait_cnt + TW'(1);
                err_nxt  = err_timeout || timed_out;
                if (rf_ack || timed_out) state_nxt = REL;
            end
            REL: begin
                pop = !rf_ack;
                if (!rf_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_commit.sv
// tb_wb_commit: directed and randomized checks of wb_commit against a queue-based model
module tb_wb_commit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_result;
    logic [3:0]  in_rd;
    logic        in_we;
    logic        rf_req;
    logic        rf_ack;
    logic        rf_we;
    logic [3:0]  rf_addr;
    logic [15:0] rf_data;
    logic [3:0]  fwd_addr;
    logic        fwd_hit;
    logic [15:0] fwd_data;
    logic [1:0]  pending;
    logic        err_timeout;

    int checks = 0;
    int failures = 0;

    wb_commit dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_rd      (in_rd),
        .in_we      (in_we),
        .rf_req     (rf_req),
        .rf_ack     (rf_ack),
        .rf_we      (rf_we),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .fwd_addr   (fwd_addr),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data),
        .pending    (pending),
        .err_timeout(err_timeout)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [3:0] rd, input logic [15:0] d);
        in_valid = 1; in_rd = rd; in_result = d; in_we = 1;
        step;
        in_valid = 0;
    endtask

    task automatic serve_one(output logic [3:0] a, output logic [15:0] d, output bit ok);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (rf_req) begin
                ok = 1;
                break;
            end
            step;
        end
        a = rf_addr;
        d = rf_data;
        if (ok) begin
            rf_ack = 1;
            step;
            rf_ack = 0;
            step;
        end
    endtask

    task automatic test_reset;
        rst = 1; in_valid = 1; in_we = 1; in_rd = 4'h9; in_result = 16'hdead;
        step;
        step;
        checks++; if (pending !== 2'd0) begin failures++; $display("FAIL reset_pending got=%0d exp=0", pending); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (rf_req !== 1'b0 || rf_we !== 1'b0) begin failures++; $display("FAIL reset_req got=%b/%b exp=0/0", rf_req, rf_we); end
        checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_timeout); end
        checks++; if (rf_addr !== 4'h0 || rf_data !== 16'h0) begin failures++; $display("FAIL reset_head got=%h/%h exp=0/0", rf_addr, rf_data); end
        rst = 0; in_valid = 0;
        step;
    endtask

    task automatic test_single;
        push1(4'd3, 16'h1234);
        checks++; if (pending !== 2'd1 || rf_req !== 1'b0) begin failures++; $display("FAIL single_push got=%0d/%b exp=1/0", pending, rf_req); end
        step;
        checks++; if (rf_req !== 1'b1 || rf_we !== 1'b1) begin failures++; $display("FAIL single_req got=%b/%b exp=1/1", rf_req, rf_we); end
        checks++; if (rf_addr !== 4'd3 || rf_data !== 16'h1234) begin failures++; $display("FAIL single_head got=%h/%h exp=3/1234", rf_addr, rf_data); end
        rf_ack = 1;
        step;
        checks++; if (rf_req !== 1'b0 || pending !== 2'd1) begin failures++; $display("FAIL single_rel got=%b/%0d exp=0/1", rf_req, pending); end
        rf_ack = 0;
        step;
        checks++; if (pending !== 2'd0 || rf_req !== 1'b0) begin failures++; $display("FAIL single_pop got=%0d/%b exp=0/0", pending, rf_req); end
    endtask

    task automatic test_back_to_back;
        logic [3:0] a;
        logic [15:0] d;
        bit ok;
        push1(4'd1, 16'h1111);
        push1(4'd2, 16'h2222);
        checks++; if (in_ready !== 1'b0 || pending !== 2'd2) begin failures++; $display("FAIL b2b_full got=%b/%0d exp=0/2", in_ready, pending); end
        in_valid = 1; in_rd = 4'd4; in_result = 16'h4444; in_we = 1;
        for (int i = 0; i < 3; i++) begin
            step;
            checks++; if (in_ready !== 1'b0 || pending !== 2'd2) begin failures++; $display("FAIL b2b_stall got=%b/%0d exp=0/2", in_ready, pending); end
        end
        checks++; if (rf_addr !== 4'd1 || rf_data !== 16'h1111) begin failures++; $display("FAIL b2b_first got=%h/%h exp=1/1111", rf_addr, rf_data); end
        rf_ack = 1;
        step;
        rf_ack = 0;
        step;
        checks++; if (pending !== 2'd1 || in_ready !== 1'b1) begin failures++; $display("FAIL b2b_pop got=%0d/%b exp=1/1", pending, in_ready); end
        step;
        in_valid = 0;
        checks++; if (pending !== 2'd2) begin failures++; $display("FAIL b2b_third got=%0d exp=2", pending); end
        serve_one(a, d, ok);
        checks++; if (!ok || a !== 4'd2 || d !== 16'h2222) begin failures++; $display("FAIL b2b_order2 got=%h/%h ok=%0d exp=2/2222", a, d, ok); end
        serve_one(a, d, ok);
        checks++; if (!ok || a !== 4'd4 || d !== 16'h4444) begin failures++; $display("FAIL b2b_order3 got=%h/%h ok=%0d exp=4/4444", a, d, ok); end
        checks++; if (pending !== 2'd0) begin failures++; $display("FAIL b2b_drain got=%0d exp=0", pending); end
    endtask

    task automatic test_forwarding;
        logic [3:0] a;
        logic [15:0] d;
        bit ok;
        push1(4'd5, 16'h00aa);
        push1(4'd5, 16'h00bb);
        fwd_addr = 4'd5;
        #1;
        checks++; if (fwd_hit !== 1'b1 || fwd_data !== 16'h00bb) begin failures++; $display("FAIL fwd_young got=%b/%h exp=1/00bb", fwd_hit, fwd_data); end
        fwd_addr = 4'd6;
        #1;
        checks++; if (fwd_hit !== 1'b0 || fwd_data !== 16'h0) begin failures++; $display("FAIL fwd_miss got=%b/%h exp=0/0000", fwd_hit, fwd_data); end
        serve_one(a, d, ok);
        checks++; if (!ok || a !== 4'd5 || d !== 16'h00aa) begin failures++; $display("FAIL fwd_commit got=%h/%h exp=5/00aa", a, d); end
        fwd_addr = 4'd5;
        #1;
        checks++; if (fwd_hit !== 1'b1 || fwd_data !== 16'h00bb) begin failures++; $display("FAIL fwd_head got=%b/%h exp=1/00bb", fwd_hit, fwd_data); end
        serve_one(a, d, ok);
        #1;
        checks++; if (fwd_hit !== 1'b0 || fwd_data !== 16'h0) begin failures++; $display("FAIL fwd_empty got=%b/%h exp=0/0000", fwd_hit, fwd_data); end
    endtask

    task automatic test_no_we;
        in_valid = 1; in_we = 0; in_rd = 4'd7; in_result = 16'h7777;
        step;
        in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (pending !== 2'd0 || rf_req !== 1'b0) begin failures++; $display("FAIL no_we got=%0d/%b exp=0/0", pending, rf_req); end
            step;
        end
        in_we = 1;
    endtask

    task automatic test_timeout;
        logic [3:0] a;
        logic [15:0] d;
        bit ok;
        int n;
        push1(4'd7, 16'h7777);
        push1(4'd8, 16'h8888);
        n = 0;
        while (rf_req && n < 400) begin
            n++;
            step;
        end
        checks++; if (n != 255) begin failures++; $display("FAIL timeout_len got=%0d exp=255", n); end
        checks++; if (err_timeout !== 1'b1 || rf_req !== 1'b0) begin failures++; $display("FAIL timeout_flag got=%b/%b exp=1/0", err_timeout, rf_req); end
        step;
        checks++; if (pending !== 2'd1) begin failures++; $display("FAIL timeout_pop got=%0d exp=1", pending); end
        serve_one(a, d, ok);
        checks++; if (!ok || a !== 4'd8 || d !== 16'h8888) begin failures++; $display("FAIL timeout_next got=%h/%h exp=8/8888", a, d); end
        checks++; if (err_timeout !== 1'b1 || pending !== 2'd0) begin failures++; $display("FAIL timeout_sticky got=%b/%0d exp=1/0", err_timeout, pending); end
    endtask

    task automatic test_reset_mid;
        push1(4'd9, 16'h9999);
        push1(4'd10, 16'haaaa);
        checks++; if (rf_req !== 1'b1 || pending !== 2'd2) begin failures++; $display("FAIL rstmid_pre got=%b/%0d exp=1/2", rf_req, pending); end
        rst = 1; in_valid = 1; in_we = 1; in_rd = 4'd11; in_result = 16'hbbbb;
        step;
        checks++; if (rf_req !== 1'b0 || pending !== 2'd0) begin failures++; $display("FAIL rstmid_req got=%b/%0d exp=0/0", rf_req, pending); end
        checks++; if (err_timeout !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_err got=%b/%b exp=0/1", err_timeout, in_ready); end
        checks++; if (rf_addr !== 4'h0 || rf_data !== 16'h0) begin failures++; $display("FAIL rstmid_head got=%h/%h exp=0/0", rf_addr, rf_data); end
        rst = 0; in_valid = 0;
        step;
        step;
        checks++; if (rf_req !== 1'b0 || pending !== 2'd0) begin failures++; $display("FAIL rstmid_after got=%b/%0d exp=0/0", rf_req, pending); end
    endtask

    task automatic test_random;
        logic [19:0] q[$];
        bit pop_now;
        bit tx;
        bit exp_hit;
        logic [15:0] exp_d;
        int writes;
        writes = 0;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            in_valid = (cyc < 900) && ($urandom_range(0, 1) == 1);
            in_we = $urandom_range(0, 3) != 0;
            in_rd = 4'($urandom_range(0, 15));
            in_result = 16'($urandom);
            fwd_addr = 4'($urandom_range(0, 15));
            #1;
            exp_hit = 0;
            exp_d = 16'h0;
            foreach (q[i]) if (q[i][19:16] == fwd_addr) begin exp_hit = 1; exp_d = q[i][15:0]; end
            checks++; if (fwd_hit !== exp_hit || fwd_data !== exp_d) begin failures++; $display("FAIL rnd_fwd cyc=%0d got=%b/%h exp=%b/%h", cyc, fwd_hit, fwd_data, exp_hit, exp_d); end
            checks++; if (in_ready !== (q.size() < 2)) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, in_ready, q.size() < 2); end
            checks++; if (rf_we !== rf_req) begin failures++; $display("FAIL rnd_we cyc=%0d got=%b exp=%b", cyc, rf_we, rf_req); end
            if (rf_req) begin
                checks++;
                if (q.size() == 0) begin failures++; $display("FAIL rnd_req_empty cyc=%0d got=1 exp=0", cyc); end
                else if ({rf_addr, rf_data} !== q[0]) begin failures++; $display("FAIL rnd_head cyc=%0d got=%h exp=%h", cyc, {rf_addr, rf_data}, q[0]); end
            end
            pop_now = 0;
            if (rf_ack && !rf_req) begin
                rf_ack = 0;
                pop_now = 1;
            end else if (!rf_ack && rf_req && $urandom_range(0, 2) == 0) begin
                rf_ack = 1;
                writes++;
            end
            tx = in_valid && in_ready && in_we;
            step;
            if (pop_now) void'(q.pop_front());
            if (tx) q.push_back({in_rd, in_result});
            checks++; if (pending !== 2'(q.size())) begin failures++; $display("FAIL rnd_pending cyc=%0d got=%0d exp=%0d", cyc, pending, q.size()); end
        end
        in_valid = 0;
        checks++; if (q.size() != 0 || pending !== 2'd0 || writes == 0) begin failures++; $display("FAIL rnd_drain got=%0d/%0d writes=%0d exp=0/0", q.size(), pending, writes); end
        checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL rnd_err got=%b exp=0", err_timeout); end
    endtask

    initial begin
        rst = 1; in_valid = 0; in_result = '0; in_rd = '0; in_we = 1; rf_ack = 0; fwd_addr = '0;
        test_reset;
        test_single;
        test_back_to_back;
        test_forwarding;
        test_no_we;
        test_timeout;
        test_reset_mid;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
